// File: rtl/sram_tcam_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_tcam_ctrl
// Brief    : Update/search sequencer for an SRAM-based TCAM built from 2-bit
//            sub-blocks (4-word bit-column memories) with arbitrated access.
// Revision : 1.0 - initial release
// ============================================================================
module sram_tcam_ctrl #(
  parameter  int KEY_W   = 144,
  parameter  int ENTRIES = 256,
  localparam int NBLK    = KEY_W / 2,
  localparam int IW      = $clog2(ENTRIES),
  localparam int BW      = $clog2(NBLK)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic               upd_op,
  input  logic [IW-1:0]      upd_index,
  input  logic [KEY_W-1:0]   upd_value,
  input  logic [KEY_W-1:0]   upd_mask,
  output logic               upd_done,
  input  logic               srch_valid,
  output logic               srch_ready,
  input  logic [KEY_W-1:0]   srch_key,
  output logic [KEY_W-1:0]   tcam_key,
  input  logic [ENTRIES-1:0] tcam_match,
  output logic               mem_we,
  output logic [BW-1:0]      mem_blk,
  output logic [IW-1:0]      mem_entry,
  output logic [3:0]         mem_bits,
  output logic               res_valid,
  output logic               res_hit,
  output logic [IW-1:0]      res_index
);

  localparam logic [BW-1:0] c_last_blk = BW'(NBLK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UPD  = 2'd1,
    S_SRCH = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_prio_srch;
  logic               r_op;
  logic [KEY_W-1:0]   r_val;
  logic [KEY_W-1:0]   r_msk;

  logic               w_idle;
  logic               w_upd_acc;
  logic               w_srch_acc;
  logic               w_hit;
  logic [IW-1:0]      w_idx;

  // Column word a of a sub-block matches when every cared bit agrees with a.
  function automatic logic [3:0] f_col_bits(input logic [1:0] v, input logic [1:0] m);
    logic [3:0] b;
    for (int a = 0; a < 4; a++) begin
      b[a] = ((2'(a) ^ v) & m) == 2'b00;
    end
    return b;
  endfunction

  assign w_idle     = (r_state == S_IDLE);
  assign upd_ready  = w_idle & ~(srch_valid & r_prio_srch);
  assign srch_ready = w_idle & ~(upd_valid & ~r_prio_srch);
  assign w_upd_acc  = upd_valid & upd_ready;
  assign w_srch_acc = srch_valid & srch_ready;

  always_comb begin
    w_hit = |tcam_match;
    w_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (tcam_match[i]) w_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prio_srch <= 1'b0;
      r_op        <= 1'b0;
      r_val       <= '0;
      r_msk       <= '0;
      mem_we      <= 1'b0;
      mem_blk     <= '0;
      mem_entry   <= '0;
      mem_bits    <= 4'b0000;
      upd_done    <= 1'b0;
      res_valid   <= 1'b0;
      res_hit     <= 1'b0;
      res_index   <= '0;
      tcam_key    <= '0;
    end else begin
      upd_done  <= 1'b0;
      res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_upd_acc) begin
            // Block 0 is issued straight from the request; the rest stream
            // out of the shifted value/mask copies.
            r_prio_srch <= 1'b1;
            r_op        <= upd_op;
            r_val       <= upd_value >> 2;
            r_msk       <= upd_mask >> 2;
            mem_we      <= 1'b1;
            mem_blk     <= '0;
            mem_entry   <= upd_index;
            mem_bits    <= upd_op ? 4'b0000 : f_col_bits(upd_value[1:0], upd_mask[1:0]);
            r_state     <= S_UPD;
          end else if (w_srch_acc) begin
            r_prio_srch <= 1'b0;
            tcam_key    <= srch_key;
            r_state     <= S_SRCH;
          end
        end
        S_UPD: begin
          if (r_op || (mem_blk == c_last_blk)) begin
            mem_we   <= 1'b0;
            upd_done <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            mem_blk  <= mem_blk + BW'(1);
            mem_bits <= f_col_bits(r_val[1:0], r_msk[1:0]);
            r_val    <= r_val >> 2;
            r_msk    <= r_msk >> 2;
          end
        end
        S_SRCH: begin
          res_hit   <= w_hit;
          res_index <= w_idx;
          res_valid <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_tcam_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_tcam_ctrl
// Brief    : Scoreboard bench for sram_tcam_ctrl update, search and arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_tcam_ctrl;

  localparam int KEY_W   = 144;
  localparam int ENTRIES = 256;
  localparam int NBLK    = KEY_W / 2;
  localparam int IW      = 8;
  localparam int BW      = 7;
  localparam logic [ENTRIES-1:0] JUNK = {ENTRIES{1'b1}};

  logic               clk;
  logic               rst;
  logic               upd_valid;
  logic               upd_ready;
  logic               upd_op;
  logic [IW-1:0]      upd_index;
  logic [KEY_W-1:0]   upd_value;
  logic [KEY_W-1:0]   upd_mask;
  logic               upd_done;
  logic               srch_valid;
  logic               srch_ready;
  logic [KEY_W-1:0]   srch_key;
  logic [KEY_W-1:0]   tcam_key;
  logic [ENTRIES-1:0] tcam_match;
  logic               mem_we;
  logic [BW-1:0]      mem_blk;
  logic [IW-1:0]      mem_entry;
  logic [3:0]         mem_bits;
  logic               res_valid;
  logic               res_hit;
  logic [IW-1:0]      res_index;

  typedef struct {
    int         cyc;
    int         blk;
    int         entry;
    logic [3:0] bits;
  } wr_t;

  typedef struct {
    int   cyc;
    logic hit;
    int   idx;
  } res_t;

  wr_t  exp_wr[$];
  int   exp_done[$];
  res_t exp_res[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  sram_tcam_ctrl #(.KEY_W(KEY_W), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op),
    .upd_index(upd_index), .upd_value(upd_value), .upd_mask(upd_mask),
    .upd_done(upd_done),
    .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_key(srch_key),
    .tcam_key(tcam_key), .tcam_match(tcam_match),
    .mem_we(mem_we), .mem_blk(mem_blk), .mem_entry(mem_entry), .mem_bits(mem_bits),
    .res_valid(res_valid), .res_hit(res_hit), .res_index(res_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Word a stores 1 when, for each bit j, the mask ignores it or a agrees with the value.
  function automatic logic [3:0] model_bits(input logic [1:0] v, input logic [1:0] m);
    logic [3:0] r;
    logic [1:0] a2;
    for (int a = 0; a < 4; a++) begin
      a2   = 2'(a);
      r[a] = 1'b1;
      for (int j = 0; j < 2; j++) if (m[j] && (a2[j] != v[j])) r[a] = 1'b0;
    end
    return r;
  endfunction

  function automatic int model_lowest(input logic [ENTRIES-1:0] m);
    for (int i = 0; i < ENTRIES; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic monitor();
    wr_t  e;
    res_t r;
    int   d;
    forever begin
      @(negedge clk);
      if (mem_we !== 1'b0) begin
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_bad++;
          $display("FAIL mem_write_spurious: cyc=%0d we=%b blk=%0d entry=%0d bits=%b, required no write",
                   cyc, mem_we, mem_blk, mem_entry, mem_bits);
        end else begin
          e = exp_wr.pop_front();
          if (e.cyc !== cyc || e.blk !== int'(mem_blk) || e.entry !== int'(mem_entry) || e.bits !== mem_bits) begin
            n_bad++;
            $display("FAIL mem_write: got cyc=%0d blk=%0d entry=%0d bits=%b, required cyc=%0d blk=%0d entry=%0d bits=%b",
                     cyc, mem_blk, mem_entry, mem_bits, e.cyc, e.blk, e.entry, e.bits);
          end
        end
      end
      if (upd_done !== 1'b0) begin
        n_cmp++;
        if (exp_done.size() == 0) begin
          n_bad++;
          $display("FAIL upd_done_spurious: cyc=%0d upd_done=%b, required 0", cyc, upd_done);
        end else begin
          d = exp_done.pop_front();
          if (d !== cyc) begin
            n_bad++;
            $display("FAIL upd_done_cycle: got cyc=%0d, required cyc=%0d", cyc, d);
          end
        end
      end
      if (res_valid !== 1'b0) begin
        n_cmp++;
        if (exp_res.size() == 0) begin
          n_bad++;
          $display("FAIL res_valid_spurious: cyc=%0d res_valid=%b, required 0", cyc, res_valid);
        end else begin
          r = exp_res.pop_front();
          if (r.cyc !== cyc || r.hit !== res_hit || r.idx !== int'(res_index)) begin
            n_bad++;
            $display("FAIL search_result: got cyc=%0d hit=%b idx=%0d, required cyc=%0d hit=%b idx=%0d",
                     cyc, res_hit, res_index, r.cyc, r.hit, r.idx);
          end
        end
      end
    end
  endtask

  task automatic push_upd(input logic op, input int idx, input logic [KEY_W-1:0] v,
                          input logic [KEY_W-1:0] m, input int acc);
    if (op) begin
      exp_wr.push_back('{acc + 1, 0, idx, 4'b0000});
      exp_done.push_back(acc + 2);
    end else begin
      for (int b = 0; b < NBLK; b++)
        exp_wr.push_back('{acc + 1 + b, b, idx, model_bits(v[2*b +: 2], m[2*b +: 2])});
      exp_done.push_back(acc + NBLK + 1);
    end
  endtask

  task automatic issue_upd(input logic op, input int idx, input logic [KEY_W-1:0] v,
                           input logic [KEY_W-1:0] m, output int acc, output bit ok);
    @(negedge clk);
    upd_valid = 1'b1; upd_op = op; upd_index = IW'(idx); upd_value = v; upd_mask = m;
    ok = 1'b0; acc = -1;
    for (int t = 0; t < 200; t++) begin
      #1;
      if (upd_ready === 1'b1) begin ok = 1'b1; acc = cyc; break; end
      @(negedge clk);
    end
    if (ok) push_upd(op, idx, v, m, acc);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic issue_srch(input logic [KEY_W-1:0] key, input logic [ENTRIES-1:0] match,
                            output int acc, output bit ok);
    @(negedge clk);
    srch_valid = 1'b1; srch_key = key; tcam_match = JUNK;
    ok = 1'b0; acc = -1;
    for (int t = 0; t < 200; t++) begin
      #1;
      if (srch_ready === 1'b1) begin ok = 1'b1; acc = cyc; break; end
      @(negedge clk);
    end
    if (!ok) begin srch_valid = 1'b0; return; end
    exp_res.push_back('{acc + 2, |match, model_lowest(match)});
    @(posedge clk); #1;
    tcam_match = match; srch_valid = 1'b0;
    @(posedge clk); #1;
    tcam_match = JUNK;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (exp_wr.size() == 0 && exp_done.size() == 0 && exp_res.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({mem_we, upd_done, res_valid, res_hit, res_index, tcam_key, mem_blk, mem_entry, mem_bits} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: we=%b done=%b rv=%b hit=%b idx=%0d key=%h blk=%0d entry=%0d bits=%b, required all 0",
               mem_we, upd_done, res_valid, res_hit, res_index, tcam_key, mem_blk, mem_entry, mem_bits);
    end
    n_cmp++;
    if (upd_ready !== 1'b1 || srch_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: upd_ready=%b srch_ready=%b, required 1 1", upd_ready, srch_ready);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (tcam_key !== '0 || mem_blk !== '0 || res_index !== '0) begin
      n_bad++;
      $display("FAIL idle_after_reset: key=%h blk=%0d idx=%0d, required 0", tcam_key, mem_blk, res_index);
    end
  endtask

  task automatic test_write();
    int acc;
    bit ok;
    logic [KEY_W-1:0] v, m;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin issue_upd(1'b0, 5, '0, '1, acc, ok); end
        1: begin v = '0; for (int k = 0; k < KEY_W; k++) v[k] = 1'($urandom_range(1, 0));
                 issue_upd(1'b0, 3, v, '0, acc, ok); end
        2: begin issue_upd(1'b1, 3, '1, '1, acc, ok); end
        default: begin
          for (int k = 0; k < KEY_W; k++) begin
            v[k] = 1'($urandom_range(1, 0)); m[k] = 1'($urandom_range(1, 0));
          end
          issue_upd(1'b0, 200, v, m, acc, ok);
        end
      endcase
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL write_accept case=%0d: accepted=%0d, required 1", c, ok); end
      wait_drain(ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL write_complete case=%0d: pending wr=%0d done=%0d, required 0 0", c, exp_wr.size(), exp_done.size());
        exp_wr.delete(); exp_done.delete();
      end
    end
  endtask

  task automatic test_search();
    int acc;
    bit ok;
    logic [ENTRIES-1:0] m;
    logic [KEY_W-1:0]   key;
    for (int c = 0; c < 3; c++) begin
      m = '0;
      case (c)
        0: begin m[9] = 1'b1; m[200] = 1'b1; end
        1: m = '0;
        default: m[ENTRIES-1] = 1'b1;
      endcase
      for (int k = 0; k < KEY_W; k++) key[k] = 1'($urandom_range(1, 0));
      issue_srch(key, m, acc, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL search_accept case=%0d: accepted=%0d, required 1", c, ok); end
      n_cmp++;
      if (tcam_key !== key) begin
        n_bad++;
        $display("FAIL tcam_key case=%0d: got %h, required %h", c, tcam_key, key);
      end
      wait_drain(ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL search_complete case=%0d: pending res=%0d, required 0", c, exp_res.size());
        exp_res.delete();
      end
    end
  endtask

  task automatic test_alternate();
    int  order[4];
    int  got;
    bit  u, s, ok;
    logic [ENTRIES-1:0] m;
    m = '0; m[17] = 1'b1; m[100] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    upd_op = 1'b1; upd_index = IW'(7); upd_value = '0; upd_mask = '0;
    srch_key = '1; tcam_match = m;
    upd_valid = 1'b1; srch_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = 0;
    for (int t = 0; t < 60 && got < 4; t++) begin
      #1;
      u = upd_valid & upd_ready;
      s = srch_valid & srch_ready;
      n_cmp++;
      if (u && s) begin n_bad++; $display("FAIL dual_handshake: cyc=%0d upd=%b srch=%b, required at most one", cyc, u, s); end
      if (u) begin push_upd(1'b1, 7, '0, '0, cyc); order[got] = 1; got++; end
      else if (s) begin exp_res.push_back('{cyc + 2, 1'b1, 17}); order[got] = 2; got++; end
      @(negedge clk);
    end
    upd_valid = 1'b0; srch_valid = 1'b0;
    n_cmp++;
    if (got !== 4) begin n_bad++; $display("FAIL alternate_count: got %0d accepts, required 4", got); end
    for (int i = 0; i < got; i++) begin
      n_cmp++;
      if (order[i] !== ((i % 2 == 0) ? 1 : 2)) begin
        n_bad++;
        $display("FAIL alternate_order[%0d]: got %0d, required %0d (1=upd 2=srch)", i, order[i], (i % 2 == 0) ? 1 : 2);
      end
    end
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL alternate_complete: pending wr=%0d done=%0d res=%0d, required 0", exp_wr.size(), exp_done.size(), exp_res.size());
      exp_wr.delete(); exp_done.delete(); exp_res.delete();
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok;
    issue_upd(1'b0, 77, '0, '1, acc, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL reset_mid_accept: accepted=%0d, required 1", ok); end
    while (cyc < acc + 31) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || upd_done !== 1'b0 || mem_blk !== '0 || tcam_key !== '0 || res_hit !== 1'b0 || res_index !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: we=%b done=%b blk=%0d key=%h hit=%b idx=%0d, required all 0",
               mem_we, upd_done, mem_blk, tcam_key, res_hit, res_index);
    end
    n_cmp++;
    if (exp_wr.size() !== NBLK - 31) begin
      n_bad++;
      $display("FAIL reset_mid_writes: remaining %0d, required %0d", exp_wr.size(), NBLK - 31);
    end
    exp_wr.delete(); exp_done.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid_ready: upd_ready=%b, required 1", upd_ready); end
    upd_valid = 1'b1; srch_valid = 1'b1;
    #1;
    n_cmp++;
    if (upd_ready !== 1'b1 || srch_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_prio: upd_ready=%b srch_ready=%b, required 1 0", upd_ready, srch_ready);
    end
    #1 upd_valid = 1'b0; srch_valid = 1'b0;
  endtask

  task automatic test_search_during_upd();
    int acc_u, acc_s;
    bit ok_u, ok_s, ok;
    logic [KEY_W-1:0] v;
    logic [ENTRIES-1:0] m;
    for (int k = 0; k < KEY_W; k++) v[k] = 1'($urandom_range(1, 0));
    m = '0; m[60] = 1'b1;
    issue_upd(1'b0, 42, v, '1, acc_u, ok_u);
    issue_srch(~v, m, acc_s, ok_s);
    n_cmp++;
    if (!ok_u || !ok_s || acc_s !== acc_u + NBLK + 1) begin
      n_bad++;
      $display("FAIL search_during_upd: upd_ok=%0d srch_ok=%0d srch_acc=%0d, required srch_acc=%0d",
               ok_u, ok_s, acc_s, acc_u + NBLK + 1);
    end
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL search_during_upd_complete: pending wr=%0d done=%0d res=%0d, required 0",
               exp_wr.size(), exp_done.size(), exp_res.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    upd_valid = 1'b0; upd_op = 1'b0; upd_index = '0; upd_value = '0; upd_mask = '0;
    srch_valid = 1'b0; srch_key = '0; tcam_match = '0;
    #1 rst = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_write();
    test_search();
    test_alternate();
    test_reset_mid();
    test_search_during_upd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
